// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter feeding the seven-segment scan stage.
// One add-3/shift iteration per clock; the result and overflow flag hold between conversions.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic [1:0]            dbg_state
);

    // Handshake: a value transfers on a rising edge where in_valid and in_ready are both 1;
    // out_valid is a one-cycle pulse marking the edge on which bcd/ovf were refreshed.

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    function automatic logic [63:0] calc_max(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL = calc_max(DIGITS);

    // The overflow compare and MAX are carried in 64 bits, so both widths must stay within that.
    generate
        if (BIN_W < 1 || BIN_W > 64 || DIGITS < 1 || DIGITS > 19 || SR_W != BCD_W + BIN_W) begin : g_bad_params
            $error("bin_to_bcd_seq: unsupported BIN_W/DIGITS combination");
        end
    endgenerate

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [SR_W-1:0]  sr_q,        sr_d;
    logic             ovf_pend_q,  ovf_pend_d;
    logic [BCD_W-1:0] bcd_q,       bcd_d;
    logic             ovf_q,       ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [SR_W-1:0]  sr_adj;
    logic [SR_W-1:0]  sr_shl;
    logic [63:0]      in_wide;
    logic             ovf_in;

    assign in_wide = 64'(in_bin);
    assign ovf_in  = (in_wide > MAX_VAL);

    // Every BCD nibble is corrected independently before the common shift.
    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr_q[BIN_W + 4*i +: 4] >= 4'd5) begin
                sr_adj[BIN_W + 4*i +: 4] = sr_q[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        sr_shl = sr_adj << 1;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        ovf_pend_d  = ovf_pend_q;
        bcd_d       = bcd_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sr_d       = {{BCD_W{1'b0}}, in_bin};
                    ovf_pend_d = ovf_in;
                    cnt_d      = '0;
                    state_d    = ST_CONV;
                end
            end
            ST_CONV: begin
                sr_d  = sr_shl;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    // Out-of-range inputs still run the full loop so latency stays fixed.
                    bcd_d       = ovf_pend_q ? {DIGITS{4'h9}} : sr_shl[SR_W-1 -: BCD_W];
                    ovf_d       = ovf_pend_q;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            ovf_pend_q  <= 1'b0;
            bcd_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            ovf_pend_q  <= ovf_pend_d;
            bcd_q       <= bcd_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign bcd       = bcd_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential double-dabble converter. Turns a binary count into packed BCD digits for the 6-digit multiplexed seven-segment display stage, which sits directly downstream. It replaces the combinational divide/modulo digit split with one add-3/shift iteration per clock. A valid/ready handshake takes in the input, and the result is held stable between conversions so the display always scans a coherent value.

Parameters:
BIN_W, 20, width of the binary input; sets the conversion length in cycles.
DIGITS, 6, number of BCD output digits; saturation limit MAX = 10^DIGITS - 1 (999999 at default).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous active-low reset (0 = reset asserted).
in_valid  input  1  in_bin holds a value to convert.
in_ready  output  1  block is idle and can accept a value.
in_bin  input  BIN_W  unsigned binary value.
out_valid  output  1  one-cycle pulse: bcd/ovf were updated on this edge.
bcd  output  4*DIGITS  packed BCD result; digit 0 (units) in [3:0], digit DIGITS-1 in the top nibble; held between conversions.
ovf  output  1  last accepted in_bin exceeded MAX; held alongside bcd.

Behaviour:
- Reset values (asynchronous, on reset=0): state IDLE, in_ready=1, out_valid=0, bcd=0, ovf=0, iteration counter=0, shift register=0.
- Accept: a transfer occurs on a rising edge where in_valid=1 and in_ready=1 (edge E0).
  - On E0: load the shift register with {4*DIGITS zeros, in_bin}.
  - On E0: latch ovf_pending = (in_bin > MAX). The comparison is unsigned and uses the full BIN_W width.
  - On E0: counter=0, state IDLE->CONV, in_ready=0.
- CONV, each cycle:
  - Every BCD nibble >= 5 gets +3. Nibbles are adjusted independently and all in the same cycle.
  - Then the whole register shifts left by 1.
  - Counter increments each cycle. The iteration where counter == BIN_W-1 is the last one.
- Completion on edge E0+BIN_W:
  - bcd <= adjusted/shifted BCD field. If ovf_pending, bcd <= all nibbles 4'h9 instead.
  - ovf <= ovf_pending, out_valid <= 1, in_ready <= 1, state -> IDLE.
- out_valid is high for exactly one cycle, then 0. There is no output backpressure; downstream samples bcd at any time.
- Latency: accept edge to result edge = BIN_W cycles (20 at default). Minimum spacing between accepts = BIN_W+1 cycles.
- in_valid while in CONV (in_ready=0) is ignored. in_bin is not sampled after E0, so changes during conversion have no effect.
- bcd and ovf change only on completion edges and on reset. Between those edges they hold.
- Overflow: in_bin = MAX converts normally with ovf=0. in_bin = MAX+1 through 2^BIN_W-1 gives saturated 9s with ovf=1, and latency is unchanged.
- Reset mid-conversion aborts immediately:
  - No out_valid is produced.
  - bcd and ovf return to 0, and in_ready returns to 1.
  - After release, a new accept is possible on the first edge.
- No arithmetic overflow can occur inside a nibble: the add-3 applies only to values 5..9, giving 8..12, and the shift keeps every nibble in 0..9.
- An internal width check must hold: 4*DIGITS+BIN_W bits fits the shift register. No bit is lost for in_bin <= MAX.

Test Plan:
- Reset release, in_bin=0 accepted -> in_ready=0 for cycles E0+1..E0+19; out_valid pulses exactly at E0+20; bcd=24'h000000, ovf=0.
- in_bin=123456 -> bcd=24'h123456, ovf=0, out_valid pulse one cycle wide; bcd still 24'h123456 50 cycles later.
- in_bin=999999 -> bcd=24'h999999, ovf=0; then in_bin=1000000 -> bcd=24'h999999, ovf=1; then in_bin=1048575 -> bcd=24'h999999, ovf=1.
- in_valid held high continuously with in_bin changing every cycle -> accepts only on edges where in_ready=1, spaced 21 cycles apart. Each result matches the in_bin value present on its accept edge.
- Accept in_bin=654321, assert reset at E0+10 for 2 cycles -> no out_valid; bcd=0, ovf=0, in_ready=1 during reset. Post-release accept of 42 -> bcd=24'h000042 at 20 cycles.
- Random sweep of 1000 in_bin values across 0..2^20-1 against a reference model -> all bcd/ovf match, every latency is 20, every out_valid is a single cycle.
